sar_result_capture: RTL and testbench
=====================================

SAR_RESULT_CAPTURE -- requirements
Module: sar_result_capture

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): SAR_W, 10, conversion result width; FIFO_DEPTH, 4, result FIFO entries (power of 2); ACC_W, SAR_W+3, accumulator width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sar  input  SAR_W  conversion result from the SAR logic; valid while eoc high.
REQ-005 eoc  input  1  end of conversion from the SAR logic; level, may stay high several cycles.
REQ-006 avg_log2  input  2  averaging window = 2^avg_log2 samples (1, 2, 4 or 8).
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 out_ready  input  1  downstream accepts head entry.
REQ-009 out_data  output  SAR_W  FIFO head entry; 0 when FIFO empty.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 fifo_count  output  3  entries held (0..FIFO_DEPTH).
REQ-012 overflow  output  1  sticky; a result was dropped because the FIFO was full.

Function
REQ-013 Capture edge E SHALL be any clk edge where eoc=1 and the registered previous eoc=0; sar is sampled at E; a held-high eoc SHALL yield exactly one sample.
REQ-014 At E the sample SHALL be added to a zero-extended ACC_W accumulator and the sample counter incremented.
REQ-015 The window length SHALL be latched from avg_log2 at the first capture of each window; changes mid-window SHALL take effect only at the next window.
REQ-016 When the counter reaches 2^N (N = latched value), result = accumulator >> N (truncation); accumulator and counter SHALL clear at that same edge E.
REQ-017 The result SHALL be pushed into the FIFO at edge E+1; out_valid SHALL rise after E+1 when the FIFO was empty (2-cycle latency, N=0).
REQ-018 A pop SHALL occur on any edge with out_valid=1 and out_ready=1; out_data then presents the next entry.
REQ-019 Push while full with no pop: the new result SHALL be dropped, FIFO contents unchanged, overflow set.
REQ-020 Simultaneous push and pop while full SHALL accept both; fifo_count unchanged, no overflow.
REQ-021 Simultaneous push and pop while empty: the pop is void (out_valid=0); push accepted, count becomes 1.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count derives from an extra pointer bit.
REQ-023 overflow SHALL clear on ovf_clr=1 unless a drop occurs on the same edge (set wins).
REQ-024 The accumulator SHALL never overflow: 8 x (2^SAR_W - 1) fits ACC_W.

Reset
REQ-025 With rst=1 at an edge: out_data=0, out_valid=0, fifo_count=0, overflow=0, accumulator=0, counter=0, eoc history=0, pending push cleared.
REQ-026 rst mid-window or mid-push SHALL discard the partial accumulation and any pending result.
REQ-027 An eoc already high when rst deasserts SHALL count as a capture on the first edge after reset (history=0).

Structure
REQ-028 SAR_W, FIFO_DEPTH and ACC_W defaults SHALL live in the shared package sar_pkg.
REQ-029 The FIFO SHALL be one sub-module, sar_result_fifo (synchronous, first-word-fall-through, count/full/empty outputs).
REQ-030 Edge detect, accumulator and window control SHALL stay in the top module.

Verification
REQ-031 avg_log2=0, eoc pulse sar=10'h2A5, out_ready=1 -> out_valid high 2 cycles after E, out_data=10'h2A5, fifo_count returns to 0.
REQ-032 avg_log2=2, samples 100,101,102,104 -> one result 101 (407>>2), no output after the first three.
REQ-033 out_ready=0, avg_log2=0, 5 conversions 1..5 -> fifo_count=4, overflow=1, drain gives 1,2,3,4; ovf_clr then clears overflow.
REQ-034 FIFO full, out_ready=1 held during a fifth push -> count stays 4, overflow=0, order preserved.
REQ-035 eoc held high 6 cycles -> single sample; rst asserted after 2 of 4 samples (avg_log2=2) -> after reset, 4 new samples of 8 yield exactly 8.
REQ-036 avg_log2 changed 3->0 after the 3rd of 8 samples -> window completes at 8 samples, following samples emit individually.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared defaults and helpers for the SAR result capture block.
package sar_pkg;

   localparam int unsigned SAR_W_DEF      = 10;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   // 8 x (2^SAR_W - 1) needs SAR_W + 3 bits
   localparam int unsigned ACC_W_DEF      = SAR_W_DEF + 3;
   localparam int unsigned CNT_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;

   // Number of samples in an averaging window of 2^n.
   function automatic logic [3:0] win_len(input logic [1:0] n);
      return 4'd1 << n;
   endfunction

endpackage

// File: rtl/sar_result_capture_if.sv
// Handshake bundle between SAR logic, the capture block and the result consumer.
interface sar_result_capture_if #(
   parameter int unsigned SAR_W = sar_pkg::SAR_W_DEF,
   parameter int unsigned CNT_W = sar_pkg::CNT_W_DEF
);
   logic [SAR_W-1:0] sar;
   logic             eoc;
   logic [1:0]       avg_log2;
   logic             ovf_clr;
   logic             out_ready;
   logic [SAR_W-1:0] out_data;
   logic             out_valid;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;

   modport slave (
      input  sar, eoc, avg_log2, ovf_clr, out_ready,
      output out_data, out_valid, fifo_count, overflow
   );

   modport master (
      output sar, eoc, avg_log2, ovf_clr, out_ready,
      input  out_data, out_valid, fifo_count, overflow
   );
endinterface

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result FIFO; pointers carry one extra wrap bit for the count.
module sar_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 10,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_pop;
   logic         w_wen;

   assign o_count = r_wptr - r_rptr;
   assign o_empty = (o_count == '0);
   assign o_full  = (o_count == (AW+1)'(DEPTH));
   // A pop on an empty FIFO is void; a push while full only lands if a pop frees the slot
   assign w_pop   = i_pop & ~o_empty;
   assign w_wen   = i_push & (~o_full | w_pop);
   assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   // Pointer update and storage write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wen) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
            r_wptr                <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: rtl/sar_result_capture.sv
// Captures SAR conversion results on eoc rising edges, averages over 2^N samples
// and queues each averaged result in a small FIFO.
module sar_result_capture
   import sar_pkg::*;
#(
   parameter int unsigned SAR_W      = SAR_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned ACC_W      = SAR_W + 3
) (
   input  logic               clk,
   input  logic               rst,
   sar_result_capture_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             r_eoc_prev;
   logic [ACC_W-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic [1:0]       r_n;
   logic [SAR_W-1:0] r_res;
   logic             r_push;
   logic             r_ovf;

   logic             w_cap;
   logic [1:0]       w_n;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [3:0]       w_cnt_nxt;
   logic             w_done;
   logic [ACC_W-1:0] w_shift;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;
   logic [CNT_W-1:0] w_count;

   assign w_cap     = bus.eoc & ~r_eoc_prev;
   // First capture of a window uses the live avg_log2; later ones use the latched value
   assign w_n       = (r_cnt == 4'd0) ? bus.avg_log2 : r_n;
   assign w_acc_nxt = r_acc + ACC_W'(bus.sar);
   assign w_cnt_nxt = r_cnt + 4'd1;
   assign w_done    = w_cap && (w_cnt_nxt == win_len(w_n));
   assign w_shift   = w_acc_nxt >> w_n;
   assign w_drop    = r_push & w_full & ~(bus.out_ready & ~w_empty);

   // Edge detect, accumulation, window control and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_eoc_prev <= 1'b0;
         r_acc      <= '0;
         r_cnt      <= 4'd0;
         r_n        <= 2'd0;
         r_res      <= '0;
         r_push     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_eoc_prev <= bus.eoc;
         r_push     <= w_done;
         if (w_done) r_res <= w_shift[SAR_W-1:0];
         if (w_cap) begin
            if (r_cnt == 4'd0) r_n <= bus.avg_log2;
            if (w_done) begin
               r_acc <= '0;
               r_cnt <= 4'd0;
            end else begin
               r_acc <= w_acc_nxt;
               r_cnt <= w_cnt_nxt;
            end
         end
         if (w_drop) r_ovf <= 1'b1;
         else if (bus.ovf_clr) r_ovf <= 1'b0;
      end
   end

   sar_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_push),
      .i_data  (r_res),
      .i_pop   (bus.out_ready),
      .o_data  (bus.out_data),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.out_valid  = ~w_empty;
   assign bus.fifo_count = w_count;
   assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_sar_result_capture.sv
// Directed bench for sar_result_capture: averaging table plus FIFO/reset corner sequences.
module tb_sar_result_capture;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   sar_result_capture_if #(.SAR_W(10), .CNT_W(3)) bus ();

   sar_result_capture #(
      .SAR_W      (10),
      .FIFO_DEPTH (4),
      .ACC_W      (13)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [1:0]       avg;
      logic [3:0]       n;
      logic [7:0][9:0]  s;
      logic [9:0]       exp;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.eoc = 1'b0;
      bus.ovf_clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // One conversion: E at the first edge, push edge E+1 at the second
   task automatic conv(input logic [9:0] v);
      bus.sar = v;
      bus.eoc = 1'b1;
      tick();
      bus.eoc = 1'b0;
      tick();
   endtask

   function automatic vec_t mk(input logic [1:0] avg, input int n,
                               input int s0, input int s1, input int s2, input int s3,
                               input int s4, input int s5, input int s6, input int s7,
                               input int exp);
      vec_t v;
      v.avg = avg;
      v.n   = 4'(n);
      v.s[0] = 10'(s0); v.s[1] = 10'(s1); v.s[2] = 10'(s2); v.s[3] = 10'(s3);
      v.s[4] = 10'(s4); v.s[5] = 10'(s5); v.s[6] = 10'(s6); v.s[7] = 10'(s7);
      v.exp = 10'(exp);
      return v;
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.sar = '0;
      bus.eoc = 1'b0;
      bus.avg_log2 = 2'd0;
      bus.ovf_clr = 1'b0;
      bus.out_ready = 1'b0;

      vecs[0] = mk(2'd0, 1, 'h2A5, 0, 0, 0, 0, 0, 0, 0, 'h2A5);
      vecs[1] = mk(2'd1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 3);
      vecs[2] = mk(2'd2, 4, 100, 101, 102, 104, 0, 0, 0, 0, 101);
      vecs[3] = mk(2'd3, 8, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023);
      vecs[4] = mk(2'd3, 8, 1, 2, 3, 4, 5, 6, 7, 9, 4);
      vecs[5] = mk(2'd1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mk(2'd2, 4, 1023, 1023, 1023, 1022, 0, 0, 0, 0, 1022);

      // Reset state
      do_reset();
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_count", int'(bus.fifo_count), 0);
      check("rst_overflow", int'(bus.overflow), 0);

      // Averaging table
      for (int i = 0; i < 7; i++) begin
         do_reset();
         bus.out_ready = 1'b0;
         bus.avg_log2 = vecs[i].avg;
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            if (k == int'(vecs[i].n) - 1 && k > 0)
               check($sformatf("v%0d_no_early_result", i), int'(bus.fifo_count), 0);
            conv(vecs[i].s[k]);
         end
         check($sformatf("v%0d_count", i), int'(bus.fifo_count), 1);
         check($sformatf("v%0d_data", i), int'(bus.out_data), int'(vecs[i].exp));
      end

      // Latency with N=0 and simultaneous push/pop on an empty FIFO
      do_reset();
      bus.avg_log2 = 2'd0;
      bus.out_ready = 1'b1;
      bus.sar = 10'h2A5;
      bus.eoc = 1'b1;
      tick();
      check("lat_valid_after_E", int'(bus.out_valid), 0);
      bus.eoc = 1'b0;
      tick();
      check("lat_valid_after_E1", int'(bus.out_valid), 1);
      check("lat_data", int'(bus.out_data), 'h2A5);
      check("lat_count", int'(bus.fifo_count), 1);
      tick();
      check("lat_drained", int'(bus.fifo_count), 0);
      check("lat_valid_low", int'(bus.out_valid), 0);

      // Overflow on full FIFO, drain order, ovf_clr
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) conv(10'(k));
      check("ovf_count", int'(bus.fifo_count), 4);
      check("ovf_flag", int'(bus.overflow), 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf_drain%0d", k), int'(bus.out_data), k);
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end
      check("ovf_empty", int'(bus.fifo_count), 0);
      check("ovf_sticky", int'(bus.overflow), 1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", int'(bus.overflow), 0);

      // Push and pop together while full
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) conv(10'(k));
      bus.sar = 10'd5;
      bus.eoc = 1'b1;
      tick();
      bus.eoc = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("fullpp_count", int'(bus.fifo_count), 4);
      check("fullpp_ovf", int'(bus.overflow), 0);
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("fullpp_order%0d", k), int'(bus.out_data), k);
         tick();
      end
      check("fullpp_empty", int'(bus.fifo_count), 0);

      // Held-high eoc yields one sample
      do_reset();
      bus.out_ready = 1'b0;
      bus.avg_log2 = 2'd0;
      bus.sar = 10'd7;
      bus.eoc = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      bus.eoc = 1'b0;
      tick();
      tick();
      check("held_eoc_count", int'(bus.fifo_count), 1);

      // Reset mid-window discards partial accumulation
      do_reset();
      bus.avg_log2 = 2'd2;
      conv(10'd50);
      conv(10'd60);
      do_reset();
      check("midwin_rst_count", int'(bus.fifo_count), 0);
      for (int k = 0; k < 4; k++) conv(10'd8);
      check("midwin_count", int'(bus.fifo_count), 1);
      check("midwin_data", int'(bus.out_data), 8);

      // Reset between E and E+1 drops the pending result
      do_reset();
      bus.avg_log2 = 2'd0;
      bus.sar = 10'd5;
      bus.eoc = 1'b1;
      tick();
      rst = 1'b1;
      bus.eoc = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("midpush_rst_count", int'(bus.fifo_count), 0);

      // eoc already high as reset deasserts counts as a capture
      rst = 1'b1;
      bus.avg_log2 = 2'd0;
      bus.sar = 10'd9;
      bus.eoc = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.eoc = 1'b0;
      tick();
      check("eoc_at_rst_count", int'(bus.fifo_count), 1);
      check("eoc_at_rst_data", int'(bus.out_data), 9);

      // avg_log2 change mid-window waits for the next window
      do_reset();
      bus.avg_log2 = 2'd3;
      for (int k = 0; k < 3; k++) conv(10'd16);
      bus.avg_log2 = 2'd0;
      for (int k = 0; k < 4; k++) conv(10'd16);
      check("win_chg_7", int'(bus.fifo_count), 0);
      conv(10'd16);
      check("win_chg_8_count", int'(bus.fifo_count), 1);
      conv(10'd5);
      conv(10'd6);
      check("win_chg_after_count", int'(bus.fifo_count), 3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("win_chg_pop%0d", k), int'(bus.out_data), (k == 0) ? 16 : k + 4);
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
